// File: rtl/pu_spi_pkg.sv
// Shared definitions for the SPI slave receiver.
//   state_t     : receiver FSM state (IDLE, RECV)
//   SYNC_STAGES : depth of the input synchronizers for the raw SPI pins
package pu_spi_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  typedef logic [0:0] state_t;

  localparam state_t IDLE = 1'b0;
  localparam state_t RECV = 1'b1;

endpackage

// File: rtl/pu_spi_sync.sv
// Multi-stage flop synchronizer for one asynchronous input bit.
//   clk, rst_n : system clock, async active-low reset
//   d_i        : raw asynchronous input
//   q_o        : synchronized output (STAGES clk cycles of latency)
// RST_VAL sets the level the chain resets to, so idle pins look idle.
module pu_spi_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pu_spi_slave_receiver.sv
// SPI mode-0 slave receiver: samples MOSI on SCLK rising edges (oversampled
// by clk) and presents each completed word on data_out with a ready pulse.
//   clk, rst             : system clock, async active-low reset
//   spi_sclk/cs_n/mosi   : raw asynchronous SPI pins
//   data_out             : last complete word (held between ready pulses)
//   ready                : one-cycle pulse, data_out is new
//   busy                 : frame active (RECV)
//   frame_error          : one-cycle pulse, CS rose mid-word
// Build option: define SPI_RX_LSB_FIRST_EN to receive LSB first
// (default MSB first).
module pu_spi_slave_receiver
  import pu_spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ready,
  output logic                  busy,
  output logic                  frame_error
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic sclk_s, cs_n_s, mosi_s;

  // Bring the raw pins into the clk domain, resetting to idle bus levels
  pu_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst), .d_i(spi_sclk), .q_o(sclk_s)
  );
  pu_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
    .clk(clk), .rst_n(rst), .d_i(spi_cs_n), .q_o(cs_n_s)
  );
  pu_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst), .d_i(spi_mosi), .q_o(mosi_s)
  );

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    sclk_prev_q;
  logic                    ready_q, ready_d;
  logic                    ferr_q, ferr_d;
  logic                    busy_q, busy_d;
  logic                    sclk_rise_c;
  logic [DATA_WIDTH-1:0]   word_c;

  assign sclk_rise_c = sclk_s & ~sclk_prev_q;

  // Shift register contents after accepting the current MOSI bit
`ifdef SPI_RX_LSB_FIRST_EN
  assign word_c = {mosi_s, shift_q[DATA_WIDTH-1:1]};
`else
  assign word_c = {shift_q[DATA_WIDTH-2:0], mosi_s};
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      sclk_prev_q <= 1'b0;
      ready_q     <= 1'b0;
      ferr_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      sclk_prev_q <= sclk_s;
      ready_q     <= ready_d;
      ferr_q      <= ferr_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and output decode; CS rise wins over a coincident SCLK edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cs_n_s) begin
          state_d = RECV;
          cnt_d   = '0;
        end
      end
      RECV: begin
        if (cs_n_s) begin
          state_d = IDLE;
          ferr_d  = (cnt_q != '0);
          cnt_d   = '0;
          shift_d = '0;
        end else if (sclk_rise_c) begin
          shift_d = word_c;
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
            data_d  = word_c;
            ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
    endcase
    busy_d = (state_d == RECV);
  end

  assign data_out    = data_q;
  assign ready       = ready_q;
  assign busy        = busy_q;
  assign frame_error = ferr_q;

endmodule

// File: tb/tb_pu_spi_slave_receiver.sv
// Self-checking bench for pu_spi_slave_receiver (DATA_WIDTH = 8).
// Honours SPI_RX_LSB_FIRST_EN for the bit order on the wire.
module tb_pu_spi_slave_receiver;

  localparam int unsigned W = 8;
  typedef logic seq_t [8];

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         spi_sclk = 1'b0;
  logic         spi_cs_n = 1'b1;
  logic         spi_mosi = 1'b0;
  logic [W-1:0] data_out;
  logic         ready, busy, frame_error;

  int checks = 0;
  int errors = 0;
  int ready_cnt = 0;
  int ferr_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  pu_spi_slave_receiver #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .data_out(data_out), .ready(ready), .busy(busy),
    .frame_error(frame_error)
  );

  // Count every cycle each output is high; a stretched pulse counts twice
  always @(posedge clk) begin
    if (ready) begin
      ready_cnt++;
      got_q.push_back(data_out);
    end
    if (frame_error) ferr_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wire order of a word
  function automatic seq_t seq_of(input logic [7:0] w);
    seq_t s;
    for (int i = 0; i < 8; i++) begin
`ifdef SPI_RX_LSB_FIRST_EN
      s[i] = w[i];
`else
      s[i] = w[7-i];
`endif
    end
    return s;
  endfunction

  // Reference: word value implied by a wire-order bit sequence
  function automatic logic [7:0] word_of(input seq_t s);
    int v = 0;
    for (int i = 0; i < 8; i++) begin
`ifdef SPI_RX_LSB_FIRST_EN
      if (s[i]) v = v + (1 << i);
`else
      v = v * 2 + (s[i] ? 1 : 0);
`endif
    end
    return 8'(v);
  endfunction

  // SCLK = clk/8, data set up while SCLK low
  task automatic send_bit(input logic b, input bit chk_busy);
    spi_mosi = b;
    cyc(4);
    spi_sclk = 1'b1;
    if (chk_busy) check("busy_in_frame", 32'(busy), 32'd1);
    cyc(4);
    spi_sclk = 1'b0;
  endtask

  task automatic send_seq(input seq_t s, input int n, input bit chk_busy);
    for (int i = 0; i < n; i++) send_bit(s[i], chk_busy);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    cyc(4);
  endtask

  task automatic cs_high();
    cyc(6);
    spi_cs_n = 1'b1;
    cyc(8);
  endtask

  initial begin
    int r0, f0, b0, n;
    seq_t s;
    logic [7:0] exp_q[$];

    // Reset state
    cyc(3);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ferr", 32'(frame_error), 32'd0);
    rst = 1'b1;
    cyc(4);

    // Single word A5
    r0 = ready_cnt; f0 = ferr_cnt;
    cs_low();
    send_seq(seq_of(8'hA5), 8, 1'b1);
    cs_high();
    check("a5_ready_cnt", 32'(ready_cnt - r0), 32'd1);
    check("a5_data", 32'(data_out), 32'hA5);
    check("a5_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("a5_busy_after", 32'(busy), 32'd0);

    // Back-to-back words without CS toggle
    r0 = ready_cnt; f0 = ferr_cnt;
    cs_low();
    send_seq(seq_of(8'h02), 8, 1'b0);
    send_seq(seq_of(8'h03), 8, 1'b0);
    cs_high();
    check("b2b_ready_cnt", 32'(ready_cnt - r0), 32'd2);
    check("b2b_first", 32'(got_q[got_q.size()-2]), 32'h02);
    check("b2b_second", 32'(got_q[got_q.size()-1]), 32'h03);
    check("b2b_ferr", 32'(ferr_cnt - f0), 32'd0);

    // Word 11 then a 5-bit partial word
    r0 = ready_cnt; f0 = ferr_cnt;
    cs_low();
    send_seq(seq_of(8'h11), 8, 1'b0);
    send_seq(seq_of(8'hEE), 5, 1'b0);
    cs_high();
    check("part_ready_cnt", 32'(ready_cnt - r0), 32'd1);
    check("part_ferr", 32'(ferr_cnt - f0), 32'd1);
    check("part_data", 32'(data_out), 32'h11);
    check("part_busy", 32'(busy), 32'd0);

    // Reset mid-word, then 3C in the same CS-low period
    r0 = ready_cnt; f0 = ferr_cnt;
    cs_low();
    send_seq(seq_of(8'hFF), 4, 1'b0);
    cyc(2);
    rst = 1'b0;
    cyc(1);
    check("mrst_data", 32'(data_out), 32'd0);
    check("mrst_ready", 32'(ready), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_ferr", 32'(frame_error), 32'd0);
    cyc(3);
    rst = 1'b1;
    cyc(6);
    check("mrst_no_ready", 32'(ready_cnt - r0), 32'd0);
    check("mrst_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("mrst_data_hold", 32'(data_out), 32'd0);
    send_seq(seq_of(8'h3C), 8, 1'b1);
    cs_high();
    check("mrst_ready_cnt", 32'(ready_cnt - r0), 32'd1);
    check("mrst_3c", 32'(data_out), 32'h3C);
    check("mrst_ferr_after", 32'(ferr_cnt - f0), 32'd0);

    // Fixed wire sequence 1,0,1,0,0,1,0,1 reads as A5 in either bit order
    s = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    r0 = ready_cnt;
    cs_low();
    send_seq(s, 8, 1'b0);
    cs_high();
    check("seq_ready_cnt", 32'(ready_cnt - r0), 32'd1);
    check("seq_data", 32'(data_out), 32'hA5);

    // SCLK activity with CS high is ignored
    r0 = ready_cnt; f0 = ferr_cnt; b0 = busy_cnt;
    for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(1, 0)), 1'b0);
    cyc(8);
    check("idle_ready", 32'(ready_cnt - r0), 32'd0);
    check("idle_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("idle_busy", 32'(busy_cnt - b0), 32'd0);
    check("idle_data", 32'(data_out), 32'hA5);

    // Random back-to-back words
    r0 = ready_cnt;
    exp_q.delete();
    cs_low();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 8; i++) s[i] = 1'($urandom_range(1, 0));
      exp_q.push_back(word_of(s));
      send_seq(s, 8, 1'b0);
    end
    cs_high();
    check("rnd_ready_cnt", 32'(ready_cnt - r0), 32'd6);
    for (int k = 0; k < 6; k++)
      check("rnd_word", 32'(got_q[got_q.size()-6+k]), 32'(exp_q[k]));

    // Random partial word of 1..7 bits
    r0 = ready_cnt; f0 = ferr_cnt;
    n = int'($urandom_range(7, 1));
    for (int i = 0; i < 8; i++) s[i] = 1'($urandom_range(1, 0));
    cs_low();
    send_seq(s, n, 1'b0);
    cs_high();
    check("rnd_part_ferr", 32'(ferr_cnt - f0), 32'd1);
    check("rnd_part_ready", 32'(ready_cnt - r0), 32'd0);
    check("rnd_part_data", 32'(data_out), 32'(exp_q[5]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
